// File: rtl/ultrasonic_ranging_controller_pkg.sv
// ultrasonic_ctrl_pkg
//   Shared definitions for the HC-SR04 ranging controller: the controller
//   state encoding and constant functions used to turn microsecond
//   parameters into clock-cycle counts and counter widths.
//   No ports (package).
package ultrasonic_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIG,
      ST_WAIT_RISE,
      ST_MEASURE,
      ST_HOLDOFF
   } state_t;

   // Whole clock cycles in a span of 'us' microseconds.
   function automatic longint us_to_cycles(input longint clk_hz, input longint us);
      return (us * clk_hz) / longint'(1000000);
   endfunction

   // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
   function automatic int cnt_width(input longint n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ultrasonic_ranging_controller_if.sv
// ultrasonic_ranging_controller_if
//   Groups the sensor and result signals of the ranging controller.
//   en       : continuous ranging enable (into controller)
//   echo     : raw HC-SR04 ECHO, asynchronous (into controller)
//   trig     : HC-SR04 TRIG (from controller)
//   distance : echo width in whole microseconds, all-ones on timeout
//   valid    : one-cycle result strobe
//   timeout  : result qualifier, held with distance
//   busy     : controller not idle
//   master = controller side, slave = user/sensor side.
interface ultrasonic_ranging_controller_if #(
   parameter int W = 16
);
   logic         en;
   logic         echo;
   logic         trig;
   logic [W-1:0] distance;
   logic         valid;
   logic         timeout;
   logic         busy;

   modport master (
      input  en, echo,
      output trig, distance, valid, timeout, busy
   );

   modport slave (
      output en, echo,
      input  trig, distance, valid, timeout, busy
   );
endinterface

// File: rtl/ultrasonic_ranging_controller_tick.sv
// us_tick_gen
//   Restartable prescaler producing a one-cycle tick every DIV clocks.
//   After a restart the first tick is seen DIV cycles later, so counts of
//   ticks start on a clean microsecond boundary.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   restart : clears the prescaler (tick suppressed in that cycle)
//   tick    : one-cycle pulse every DIV cycles
module us_tick_gen
   import ultrasonic_ctrl_pkg::*;
#(
   parameter int DIV = 27
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);
   localparam int CW = cnt_width(longint'(DIV));
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (restart || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST) && !restart;
endmodule

// File: rtl/ultrasonic_ranging_controller.sv
// ultrasonic_ranging_controller
//   Drives an HC-SR04 ultrasonic sensor: issues TRIG pulses at a fixed
//   minimum period while enabled, measures the ECHO high time in whole
//   microseconds and reports it with a one-cycle valid strobe. A missing
//   or over-long echo reports all-ones with timeout set.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ultrasonic_ranging_controller_if.master
//           (en, echo in; trig, distance, valid, timeout, busy out)
module ultrasonic_ranging_controller
   import ultrasonic_ctrl_pkg::*;
#(
   parameter int CLK_HZ     = 27000000,
   parameter int TRIG_US    = 10,
   parameter int TIMEOUT_US = 30000,
   parameter int PERIOD_US  = 60000,
   parameter int W          = 16
) (
   input  logic clk,
   input  logic rst_n,
   ultrasonic_ranging_controller_if.master bus
);
   localparam int DIV        = int'(us_to_cycles(longint'(CLK_HZ), longint'(1)));
   localparam int TRIG_CYC   = int'(us_to_cycles(longint'(CLK_HZ), longint'(TRIG_US)));
   localparam int PERIOD_CYC = int'(us_to_cycles(longint'(CLK_HZ), longint'(PERIOD_US)));
   localparam int TRIG_W     = cnt_width(longint'(TRIG_CYC));
   localparam int PER_W      = cnt_width(longint'(PERIOD_CYC));

   localparam logic [TRIG_W-1:0] TRIG_LAST    = TRIG_W'(TRIG_CYC - 1);
   localparam logic [PER_W-1:0]  PERIOD_LAST  = PER_W'(PERIOD_CYC - 1);
   localparam logic [W-1:0]      TIMEOUT_LAST = W'(TIMEOUT_US - 1);

   if (longint'(TIMEOUT_US) >= (longint'(1) << W)) begin : g_timeout_range
      $error("TIMEOUT_US must be below 2**W");
   end

   state_t            state;
   logic              trig_r;
   logic              valid_r;
   logic              timeout_r;
   logic [W-1:0]      distance_r;
   logic [TRIG_W-1:0] trig_cnt;
   logic [PER_W-1:0]  period_cnt;
   logic [W-1:0]      us_cnt;

   logic echo_m, echo_s, echo_d;
   logic echo_rise, echo_fall;
   logic tick, tick_restart;
   logic period_done, start_trig, start_meas;

   // Two-flop synchroniser plus one delay stage for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         echo_m <= 1'b0;
         echo_s <= 1'b0;
         echo_d <= 1'b0;
      end else begin
         echo_m <= bus.echo;
         echo_s <= echo_m;
         echo_d <= echo_s;
      end
   end

   assign echo_rise = echo_s & ~echo_d;
   assign echo_fall = ~echo_s & echo_d;

   // The period counter runs in cycles rather than ticks so that the
   // prescaler restart on MEASURE entry cannot stretch the TRIG spacing.
   always_comb begin
      period_done  = (period_cnt == PERIOD_LAST);
      start_trig   = bus.en && ((state == ST_IDLE) ||
                                ((state == ST_HOLDOFF) && period_done));
      start_meas   = (state == ST_WAIT_RISE) && echo_rise;
      tick_restart = start_trig || start_meas;
   end

   us_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (tick_restart),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         trig_r     <= 1'b0;
         valid_r    <= 1'b0;
         timeout_r  <= 1'b0;
         distance_r <= '0;
         trig_cnt   <= '0;
         period_cnt <= '0;
         us_cnt     <= '0;
      end else begin
         valid_r <= 1'b0;
         if (period_cnt != PERIOD_LAST) begin
            period_cnt <= period_cnt + 1'b1;
         end

         case (state)
            ST_IDLE, ST_HOLDOFF: begin
               if (start_trig) begin
                  state      <= ST_TRIG;
                  trig_r     <= 1'b1;
                  trig_cnt   <= '0;
                  period_cnt <= '0;
               end else if (state == ST_HOLDOFF && period_done) begin
                  state <= ST_IDLE;
               end
            end

            ST_TRIG: begin
               if (trig_cnt == TRIG_LAST) begin
                  state  <= ST_WAIT_RISE;
                  trig_r <= 1'b0;
                  us_cnt <= '0;
               end else begin
                  trig_cnt <= trig_cnt + 1'b1;
               end
            end

            // Only a fresh 0->1 edge starts a measurement; echo that was
            // already high on entry produces no edge here.
            ST_WAIT_RISE: begin
               if (start_meas) begin
                  state  <= ST_MEASURE;
                  us_cnt <= '0;
               end else if (tick) begin
                  if (us_cnt == TIMEOUT_LAST) begin
                     distance_r <= '1;
                     timeout_r  <= 1'b1;
                     valid_r    <= 1'b1;
                     state      <= ST_HOLDOFF;
                  end else begin
                     us_cnt <= us_cnt + 1'b1;
                  end
               end
            end

            // A tick coinciding with the fall still counts as a completed
            // microsecond; reaching the limit wins over a simultaneous fall.
            ST_MEASURE: begin
               if (tick && (us_cnt == TIMEOUT_LAST)) begin
                  distance_r <= '1;
                  timeout_r  <= 1'b1;
                  valid_r    <= 1'b1;
                  state      <= ST_HOLDOFF;
               end else if (echo_fall) begin
                  distance_r <= us_cnt + {{(W-1){1'b0}}, tick};
                  timeout_r  <= 1'b0;
                  valid_r    <= 1'b1;
                  state      <= ST_HOLDOFF;
               end else if (tick) begin
                  us_cnt <= us_cnt + 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.trig     = trig_r;
   assign bus.valid    = valid_r;
   assign bus.timeout  = timeout_r;
   assign bus.distance = distance_r;
   assign bus.busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_ultrasonic_ranging_controller.sv
// tb_ultrasonic_ranging_controller
//   Randomised self-checking bench for ultrasonic_ranging_controller at
//   4 MHz (4 cycles/us), 2 us TRIG, 50 us timeout, 100 us period.
module tb_ultrasonic_ranging_controller;
   localparam int CYC_PER_US  = 4;
   localparam int TRIG_CYC    = 2 * CYC_PER_US;
   localparam int TIMEOUT_CYC = 50 * CYC_PER_US;
   localparam int PERIOD_CYC  = 100 * CYC_PER_US;

   logic clk;
   logic rst_n;

   ultrasonic_ranging_controller_if #(.W(16)) bus_if ();

   ultrasonic_ranging_controller #(
      .CLK_HZ     (4000000),
      .TRIG_US    (2),
      .TIMEOUT_US (50),
      .PERIOD_US  (100),
      .W          (16)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference: result for an echo held high len_cyc cycles (0 = no echo)
   function automatic logic [16:0] ref_result(input int len_cyc);
      if (len_cyc <= 0 || len_cyc >= TIMEOUT_CYC) return {1'b1, 16'hFFFF};
      return {1'b0, 16'(len_cyc / CYC_PER_US)};
   endfunction

   // Event monitor sampled on the falling edge
   int          cyc = 0;
   int          rise_cyc = 0, rise_prev = 0, n_rise = 0;
   int          n_valid = 0, v_cyc = 0, valids_since_trig = 0;
   logic [15:0] v_dist = '0, prev_dist = '0;
   logic        v_to = 1'b0, prev_to = 1'b0, prev_trig = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus_if.trig && !prev_trig) begin
         rise_prev = rise_cyc;
         rise_cyc  = cyc;
         n_rise++;
         valids_since_trig = 0;
      end
      if (bus_if.valid) begin
         check("valid_once_per_trig", 32'(valids_since_trig), 32'd0);
         valids_since_trig++;
         n_valid++;
         v_cyc  = cyc;
         v_dist = bus_if.distance;
         v_to   = bus_if.timeout;
      end
      if (rst_n && (bus_if.distance != prev_dist || bus_if.timeout != prev_to))
         check("result_changes_only_with_valid", 32'(bus_if.valid), 32'd1);
      prev_dist = bus_if.distance;
      prev_to   = bus_if.timeout;
      prev_trig = bus_if.trig;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Wait for the next TRIG rise; optionally check spacing to the previous one
   task automatic next_trig(input bit chk_space);
      int n = 0;
      while (!bus_if.trig && n < PERIOD_CYC + 50) begin
         step();
         n++;
      end
      check("trig_rise_seen", 32'(bus_if.trig), 32'd1);
      if (chk_space && bus_if.trig)
         check("trig_spacing", 32'(rise_cyc - rise_prev), 32'(PERIOD_CYC));
   endtask

   // Called with TRIG just seen high. d/len in cycles; len=0 means no echo.
   task automatic do_measure(input int d, input int len, input bit stuck, input bit drop_en);
      int w = 0;
      int n = 0;
      int fall_cyc;
      int base;
      logic [16:0] exp_r;
      if (stuck) bus_if.echo = 1'b1;
      while (bus_if.trig && w < 3 * TRIG_CYC) begin
         step();
         w++;
      end
      check("trig_width", 32'(w), 32'(TRIG_CYC));
      fall_cyc = cyc;
      base = n_valid;
      if (!stuck && len > 0) begin
         repeat (d) step();
         bus_if.echo = 1'b1;
         for (int i = 0; i < len; i++) begin
            if (drop_en && i == 10) bus_if.en = 1'b0;
            step();
         end
         bus_if.echo = 1'b0;
      end
      while (n_valid == base && n < 2 * PERIOD_CYC) begin
         step();
         n++;
      end
      check("valid_seen", 32'(n_valid - base), 32'd1);
      exp_r = ref_result(stuck ? 0 : len);
      check("distance", 32'(v_dist), 32'(exp_r[15:0]));
      check("timeout", 32'(v_to), 32'(exp_r[16]));
      if (stuck || len == 0)
         check("no_rise_valid_delay", 32'(v_cyc - fall_cyc), 32'(TIMEOUT_CYC));
      bus_if.echo = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int d;
      int len;
      int base;
      rst_n = 1'b0;
      bus_if.en = 1'b1;
      bus_if.echo = 1'b0;
      repeat (5) step();
      check("rst_trig", 32'(bus_if.trig), 32'd0);
      check("rst_valid", 32'(bus_if.valid), 32'd0);
      check("rst_distance", 32'(bus_if.distance), 32'd0);
      check("rst_busy", 32'(bus_if.busy), 32'd0);
      check("rst_timeout", 32'(bus_if.timeout), 32'd0);
      rst_n = 1'b1;
      n = 0;
      while (!bus_if.trig && n < 10) begin
         step();
         n++;
      end
      check("trig_within_2_after_reset", 32'(n >= 1 && n <= 2), 32'd1);

      do_measure(20, 80, 1'b0, 1'b0);
      next_trig(1'b1);
      do_measure(0, 0, 1'b0, 1'b0);
      next_trig(1'b1);
      do_measure(0, 0, 1'b1, 1'b0);
      next_trig(1'b1);
      do_measure(10, 60 * CYC_PER_US, 1'b0, 1'b0);
      next_trig(1'b1);

      for (int k = 0; k < 6; k++) begin
         d = int'($urandom_range(0, 120));
         if ($urandom_range(0, 1) == 1) len = int'($urandom_range(204, 240));
         else                           len = int'($urandom_range(4, 196));
         do_measure(d, len, 1'b0, 1'b0);
         next_trig(1'b1);
      end

      // Reset pulse while measuring
      n = 0;
      while (bus_if.trig && n < 20) begin
         step();
         n++;
      end
      repeat (10) step();
      bus_if.echo = 1'b1;
      repeat (20) step();
      base = n_valid;
      rst_n = 1'b0;
      step();
      check("midrst_trig", 32'(bus_if.trig), 32'd0);
      check("midrst_valid", 32'(bus_if.valid), 32'd0);
      check("midrst_distance", 32'(bus_if.distance), 32'd0);
      check("midrst_busy", 32'(bus_if.busy), 32'd0);
      repeat (3) step();
      bus_if.echo = 1'b0;
      rst_n = 1'b1;
      n = 0;
      while (!bus_if.trig && n < 10) begin
         step();
         n++;
      end
      check("midrst_fresh_trig", 32'(n >= 1 && n <= 2), 32'd1);
      check("midrst_no_valid", 32'(n_valid - base), 32'd0);
      check("midrst_distance_held", 32'(bus_if.distance), 32'd0);

      do_measure(0, 60, 1'b0, 1'b0);
      next_trig(1'b1);

      // Drop enable during MEASURE: result still reported, then stop
      do_measure(5, 100, 1'b0, 1'b1);
      base = n_rise;
      repeat (PERIOD_CYC + 100) step();
      check("stop_no_more_trig", 32'(n_rise - base), 32'd0);
      check("stop_busy_low", 32'(bus_if.busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
